// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - Shared VGA timing constants, counter type and window decode helper
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [CNT_W-1:0] cnt_t;

    // True when lo <= val < lo+len; shared with the colour stage for its window bounds.
    function automatic logic in_window(input cnt_t val, input int lo, input int len);
        return (int'(val) >= lo) && (int'(val) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - Timing bundle from the sync generator to downstream stages
interface vga_sync_gen_if;

    logic [vga_timing_pkg::CNT_W-1:0] hcount;
    logic [vga_timing_pkg::CNT_W-1:0] vcount;
    logic                             hsync;
    logic                             vsync;
    logic                             video_on;
    logic                             pix_en;
    logic                             frame_start;

    modport master (
        output hcount, vcount, hsync, vsync, video_on, pix_en, frame_start
    );

    modport slave (
        input hcount, vcount, hsync, vsync, video_on, pix_en, frame_start
    );

endinterface

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - System-clock to pixel-rate divider producing a one-clock tick
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset_n,
    output logic o_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("vga_pix_div: CLK_DIV must be in 1..16");
    end

    logic [DIV_W-1:0] r_div;

    assign o_tick = (r_div == DIV_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (o_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters, sync pulses and active-video flag
module vga_sync_gen
    import vga_timing_pkg::CNT_W, vga_timing_pkg::in_window;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP      = vga_timing_pkg::H_FP,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BP      = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP      = vga_timing_pkg::V_FP,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BP      = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic           clock,
    input  logic           reset_n,
    vga_sync_gen_if.master sync
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    logic             w_tick;
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic [CNT_W-1:0] w_hcount_nxt;
    logic [CNT_W-1:0] w_vcount_nxt;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_pix_en;
    logic             r_frame_start;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_video_on_nxt;
    logic             w_frame_start_nxt;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .clock   (clock),
        .reset_n (reset_n),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_hcount_nxt = r_hcount;
        w_vcount_nxt = r_vcount;
        if (w_tick) begin
            if (r_hcount == H_LAST) begin
                w_hcount_nxt = '0;
                w_vcount_nxt = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
            end else begin
                w_hcount_nxt = r_hcount + 1'b1;
            end
        end
    end

    // Decode from next-state counters so sync/video registers line up with the counters they describe.
    always_comb begin
        w_hsync_nxt       = !SYNC_POL;
        w_vsync_nxt       = !SYNC_POL;
        w_video_on_nxt    = 1'b0;
        w_frame_start_nxt = 1'b0;
        if (in_window(w_hcount_nxt, H_VISIBLE + H_FP, H_SYNC)) begin
            w_hsync_nxt = SYNC_POL;
        end
        if (in_window(w_vcount_nxt, V_VISIBLE + V_FP, V_SYNC)) begin
            w_vsync_nxt = SYNC_POL;
        end
        w_video_on_nxt    = in_window(w_hcount_nxt, 0, H_VISIBLE) && in_window(w_vcount_nxt, 0, V_VISIBLE);
        w_frame_start_nxt = w_tick && (w_hcount_nxt == '0) && (w_vcount_nxt == '0);
    end

    // Counters reset to the last position so the first tick wraps to (0,0) and starts a clean frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hcount      <= H_LAST;
            r_vcount      <= V_LAST;
            r_hsync       <= !SYNC_POL;
            r_vsync       <= !SYNC_POL;
            r_video_on    <= 1'b0;
            r_pix_en      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_nxt;
            r_vcount      <= w_vcount_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_video_on    <= w_video_on_nxt;
            r_pix_en      <= w_tick;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    assign sync.hcount      = r_hcount;
    assign sync.vcount      = r_vcount;
    assign sync.hsync       = r_hsync;
    assign sync.vsync       = r_vsync;
    assign sync.video_on    = r_video_on;
    assign sync.pix_en      = r_pix_en;
    assign sync.frame_start = r_frame_start;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing stage of the VGA pipeline.
- Generates the pixel-rate strobe, the horizontal/vertical counters (hcount, vcount), the sync pulses and the active-video flag.
- hcount/vcount feed the pixel colour stage (ROM-addressed colour lookup); hsync/vsync go to the VGA connector through one matching register stage in the top level.
- Default timing is 640x480 @ 60 Hz from a 50 MHz system clock (25 MHz pixel rate).

Parameters:
- CLK_DIV, 2, system clocks per pixel; legal range 1..16.
- H_VISIBLE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, active level of hsync/vsync; 0 = active-low.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- hcount  output  10  horizontal pixel counter, 0..H_TOTAL-1.
- vcount  output  10  vertical line counter, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync at SYNC_POL level during the sync window.
- vsync  output  1  vertical sync at SYNC_POL level during the sync window.
- video_on  output  1  high when hcount < H_VISIBLE and vcount < V_VISIBLE.
- pix_en  output  1  one-clock strobe, high in the cycle new counter values first appear.
- frame_start  output  1  one-clock strobe, high in the cycle counters become (0,0).

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 by default).
  - Both must be ≤ 1024; elaboration fails otherwise.
- Divider:
  - Internal counter div runs 0..CLK_DIV-1 and wraps to 0.
  - tick = (div == CLK_DIV-1).
  - CLK_DIV=1 gives a tick every clock.
- Counter advance on tick:
  - If hcount == H_TOTAL-1: hcount ← 0, and vcount ← (vcount == V_TOTAL-1) ? 0 : vcount+1.
  - Otherwise hcount ← hcount+1 and vcount holds.
  - Without a tick, all counters hold.
- All outputs are registers. hsync, vsync and video_on are computed from next-state counter values, so in every cycle they correspond exactly to the hcount/vcount presented in that same cycle (zero relative latency).
- hsync is active when H_VISIBLE+H_FP ≤ hcount < H_VISIBLE+H_FP+H_SYNC (656..751 by default).
- vsync is active when V_VISIBLE+V_FP ≤ vcount < V_VISIBLE+V_FP+V_SYNC (490..491 by default). vsync changes only together with an hcount wrap to 0.
- pix_en is the registered tick: high in exactly one clock per pixel period, the same cycle the counters update.
- frame_start is high for one clock, coincident with pix_en, when the counters update to (0,0).
- Reset (asynchronous, takes effect immediately, any time including mid-frame):
  - div=0, hcount=H_TOTAL-1, vcount=V_TOTAL-1.
  - hsync and vsync at the inactive level (~SYNC_POL).
  - video_on=0, pix_en=0, frame_start=0.
  - Reset values are chosen so the first tick after release wraps to (0,0) and raises frame_start; a clean frame always begins on reset release.
- Reset release:
  - The first pix_en occurs on the CLK_DIV-th rising edge after reset_n goes high.
  - Subsequent pix_en strobes are exactly CLK_DIV clocks apart.
- Timing invariants:
  - Frame period = H_TOTAL*V_TOTAL*CLK_DIV clocks (840000 by default).
  - Line period = H_TOTAL*CLK_DIV clocks (1600 by default).
- Downstream contract: the colour stage adds its own register/ROM latency. Sync alignment is compensated in the top level, not here.

Decomposition:
- Shared package vga_timing_pkg holds the default timing constants (H_VISIBLE..V_BP), the derived H_TOTAL/V_TOTAL, and the counter width (10). The colour stage uses the same package for its window bounds.
- One natural sub-module: vga_pix_div (divider producing tick, async active-low reset). Counters and decode stay in vga_sync_gen.

Test Plan:
- Reset release, defaults:
  - During reset: hcount=799, vcount=524, hsync=vsync=1, video_on=0.
  - The 2nd rising edge after release gives hcount=0, vcount=0, pix_en=1, frame_start=1, video_on=1.
- Line timing:
  - hsync=0 for exactly hcount 656..751, i.e. 192 clocks.
  - video_on falls at hcount=640.
  - Rising edges of hsync are 1600 clocks apart.
- Frame timing:
  - vsync=0 only for vcount 490..491, i.e. 3200 clocks.
  - frame_start pulses are 840000 clocks apart.
  - vcount wraps 524→0 together with hcount 799→0.
- CLK_DIV=1 build: pix_en is constantly high after release and the frame period is 420000 clocks. With CLK_DIV=4: pix_en is high one clock in four and the frame period is 1680000.
- Mid-frame reset: assert reset_n=0 at hcount=300, vcount=200 between clock edges → outputs take reset values immediately without waiting for a clock edge; after release a new frame_start occurs after CLK_DIV clocks.
- Alignment check: every cycle, assert that hsync, vsync and video_on equal the decode of the same-cycle hcount/vcount (scoreboard over 2 frames).
